// File: rtl/seven_seg_controlled_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : seven_seg_controlled_decoder_if
//  Description : Word-in / frame-out signal bundle for the controlled
//                seven-segment decoder.
//  Revision    : 1.0  initial release
// ============================================================================
interface seven_seg_controlled_decoder_if;
    logic        i_Valid;
    logic [15:0] i_7SegControlled;
    logic        o_Ready;
    logic [31:0] o_Frame;
    logic        o_FrameValid;
    logic        i_FrameAck;
    logic [3:0]  o_DigitMask;
    logic [1:0]  o_Error;
    logic        i_ErrClr;

    modport slave (
        input  i_Valid,
        input  i_7SegControlled,
        input  i_FrameAck,
        input  i_ErrClr,
        output o_Ready,
        output o_Frame,
        output o_FrameValid,
        output o_DigitMask,
        output o_Error
    );

    modport master (
        output i_Valid,
        output i_7SegControlled,
        output i_FrameAck,
        output i_ErrClr,
        input  o_Ready,
        input  o_Frame,
        input  o_FrameValid,
        input  o_DigitMask,
        input  o_Error
    );
endinterface
`default_nettype wire

// File: rtl/seven_seg_controlled_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : seven_seg_controlled_decoder
//  Description : Collects four controlled seven-segment words into a 32-bit
//                frame and hands it downstream with a valid/ack handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module seven_seg_controlled_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic                          i_Clk,
    input  logic                          i_Rst_n,
    seven_seg_controlled_decoder_if.slave bus
);

    typedef enum logic [0:0] {
        ST_COLLECT = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

    // Timer value seen on the edge that completes TIMEOUT_CYCLES idle cycles
    localparam logic [15:0] c_TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic        w_ready;
    logic        w_frame_valid;

    logic [7:0]  r_shadow [4];
    logic [3:0]  r_mask;
    logic [15:0] r_timer;
    logic [31:0] r_frame;
    logic [1:0]  r_error;

    logic [7:0]  w_seg;
    logic [7:0]  w_sel;
    logic        w_sel_ok;
    logic [1:0]  w_sel_pos;
    logic [3:0]  w_pos_onehot;
    logic [3:0]  w_mask_merged;
    logic        w_accept;
    logic        w_good_accept;
    logic        w_bad_accept;
    logic        w_complete;
    logic        w_timer_run;
    logic        w_timeout;
    logic [31:0] w_frame_assembled;

    assign w_seg = bus.i_7SegControlled[15:8];
    assign w_sel = bus.i_7SegControlled[7:0];

    always_comb begin
        w_sel_ok  = 1'b1;
        w_sel_pos = 2'd0;
        case (w_sel)
            8'h40:   w_sel_pos = 2'd0;
            8'h20:   w_sel_pos = 2'd1;
            8'h08:   w_sel_pos = 2'd2;
            8'h04:   w_sel_pos = 2'd3;
            default: w_sel_ok  = 1'b0;
        endcase
    end

    assign w_pos_onehot  = 4'b0001 << w_sel_pos;
    assign w_accept      = bus.i_Valid && (r_state == ST_COLLECT);
    assign w_good_accept = w_accept && w_sel_ok;
    assign w_bad_accept  = w_accept && !w_sel_ok;
    assign w_mask_merged = r_mask | w_pos_onehot;
    assign w_complete    = w_good_accept && (w_mask_merged == 4'hF);

    // A valid accept on the expiry edge restarts the window instead of timing out
    assign w_timer_run   = (r_state == ST_COLLECT) && (r_mask != 4'h0);
    assign w_timeout     = w_timer_run && !w_good_accept && (r_timer == c_TIMER_LAST);

    generate
        for (genvar g = 0; g < 4; g++) begin : g_frame_byte
            assign w_frame_assembled[8*g +: 8] =
                (w_good_accept && (w_sel_pos == 2'(g))) ? w_seg : r_shadow[g];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_state <= ST_COLLECT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_ready       = 1'b0;
        w_frame_valid = 1'b0;
        case (r_state)
            ST_COLLECT: begin
                w_ready = 1'b1;
                if (bus.i_Valid && w_sel_ok && (w_mask_merged == 4'hF)) begin
                    w_state_next = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                w_frame_valid = 1'b1;
                if (bus.i_FrameAck) begin
                    w_state_next = ST_COLLECT;
                end
            end
            default: begin
                w_state_next = ST_COLLECT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            for (int i = 0; i < 4; i++) begin
                r_shadow[i] <= 8'h00;
            end
        end else if (w_good_accept) begin
            r_shadow[w_sel_pos] <= w_seg;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_mask <= 4'h0;
        end else if (w_complete || w_timeout) begin
            r_mask <= 4'h0;
        end else if (w_good_accept) begin
            r_mask <= w_mask_merged;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_timer <= 16'h0000;
        end else if (w_good_accept || w_timeout || !w_timer_run) begin
            r_timer <= 16'h0000;
        end else begin
            r_timer <= r_timer + 16'h0001;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_frame <= 32'h0000_0000;
        end else if (w_complete) begin
            r_frame <= w_frame_assembled;
        end
    end

    // New error events take priority over a simultaneous clear
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_error <= 2'b00;
        end else begin
            r_error <= (bus.i_ErrClr ? 2'b00 : r_error) | {w_timeout, w_bad_accept};
        end
    end

    assign bus.o_Ready      = w_ready;
    assign bus.o_FrameValid = w_frame_valid;
    assign bus.o_Frame      = r_frame;
    assign bus.o_DigitMask  = r_mask;
    assign bus.o_Error      = r_error;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_controlled_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_seven_seg_controlled_decoder
//  Description : Self-checking bench for seven_seg_controlled_decoder.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seven_seg_controlled_decoder;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    seven_seg_controlled_decoder_if bus();

    seven_seg_controlled_decoder #(
        .TIMEOUT_CYCLES(8)
    ) dut (
        .i_Clk   (clk),
        .i_Rst_n (rst_n),
        .bus     (bus)
    );

    typedef struct {
        logic [15:0] word;
        logic [3:0]  mask;
        logic [1:0]  err;
        logic        done;
        logic [31:0] frame;
    } vec_t;

    vec_t        vecs [14];
    logic [31:0] exp_q [$];
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input vec_t v);
        bus.i_Valid          = 1'b1;
        bus.i_7SegControlled = v.word;
        tick();
        bus.i_Valid = 1'b0;
        chk("digit_mask", {28'h0, bus.o_DigitMask}, {28'h0, v.mask});
        chk("error", {30'h0, bus.o_Error}, {30'h0, v.err});
        if (v.done) begin
            chk("frame_valid_latency", {31'h0, bus.o_FrameValid}, 32'h1);
            chk("ready_in_present", {31'h0, bus.o_Ready}, 32'h0);
            exp_q.push_back(v.frame);
        end else begin
            chk("ready_in_collect", {31'h0, bus.o_Ready}, 32'h1);
        end
    endtask

    task automatic consume();
        int n = 0;
        logic [31:0] want;
        bus.i_Valid = 1'b0;
        while (!bus.o_FrameValid && n < 10) begin
            tick();
            n++;
        end
        chk("frame_valid_wait", {31'h0, bus.o_FrameValid}, 32'h1);
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_empty actual=frame required=none");
        end else begin
            want = exp_q.pop_front();
            chk("frame", bus.o_Frame, want);
            bus.i_FrameAck = 1'b1;
            tick();
            bus.i_FrameAck = 1'b0;
            chk("ready_after_ack", {31'h0, bus.o_Ready}, 32'h1);
            chk("valid_after_ack", {31'h0, bus.o_FrameValid}, 32'h0);
            chk("frame_held", bus.o_Frame, want);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] w, input logic [3:0] m, input logic [1:0] e,
                                input logic d, input logic [31:0] f);
        vec_t v;
        v.word = w; v.mask = m; v.err = e; v.done = d; v.frame = f;
        return v;
    endfunction

    initial begin
        vecs[0]  = mk(16'hAA40, 4'b0001, 2'b00, 1'b0, 32'h0);
        vecs[1]  = mk(16'hBB20, 4'b0011, 2'b00, 1'b0, 32'h0);
        vecs[2]  = mk(16'hCC08, 4'b0111, 2'b00, 1'b0, 32'h0);
        vecs[3]  = mk(16'hDD04, 4'b0000, 2'b00, 1'b1, 32'hDDCCBBAA);
        vecs[4]  = mk(16'h1140, 4'b0001, 2'b00, 1'b0, 32'h0);
        vecs[5]  = mk(16'h2240, 4'b0001, 2'b00, 1'b0, 32'h0);
        vecs[6]  = mk(16'h3320, 4'b0011, 2'b00, 1'b0, 32'h0);
        vecs[7]  = mk(16'h4408, 4'b0111, 2'b00, 1'b0, 32'h0);
        vecs[8]  = mk(16'h5504, 4'b0000, 2'b00, 1'b1, 32'h55443322);
        vecs[9]  = mk(16'h6640, 4'b0001, 2'b00, 1'b0, 32'h0);
        vecs[10] = mk(16'h7730, 4'b0001, 2'b01, 1'b0, 32'h0);
        vecs[11] = mk(16'h8820, 4'b0011, 2'b01, 1'b0, 32'h0);
        vecs[12] = mk(16'h9908, 4'b0111, 2'b01, 1'b0, 32'h0);
        vecs[13] = mk(16'hAA04, 4'b0000, 2'b01, 1'b1, 32'hAA998866);

        rst_n                = 1'b0;
        bus.i_Valid          = 1'b0;
        bus.i_7SegControlled = 16'h0000;
        bus.i_FrameAck       = 1'b0;
        bus.i_ErrClr         = 1'b0;
        #1;
        chk("rst_ready", {31'h0, bus.o_Ready}, 32'h1);
        chk("rst_frame_valid", {31'h0, bus.o_FrameValid}, 32'h0);
        chk("rst_frame", bus.o_Frame, 32'h0);
        chk("rst_mask", {28'h0, bus.o_DigitMask}, 32'h0);
        chk("rst_error", {30'h0, bus.o_Error}, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Table-driven frames: basic, duplicate position, invalid select
        for (int i = 0; i < 14; i++) begin
            send(vecs[i]);
            if (vecs[i].done) consume();
        end

        bus.i_ErrClr = 1'b1;
        tick();
        bus.i_ErrClr = 1'b0;
        chk("err_clear", {30'h0, bus.o_Error}, 32'h0);

        // Timeout after exactly TIMEOUT_CYCLES idle cycles
        send(mk(16'h1140, 4'b0001, 2'b00, 1'b0, 32'h0));
        repeat (7) tick();
        chk("to_mask_before", {28'h0, bus.o_DigitMask}, 32'h1);
        chk("to_err_before", {30'h0, bus.o_Error}, 32'h0);
        tick();
        chk("to_mask_after", {28'h0, bus.o_DigitMask}, 32'h0);
        chk("to_err_after", {30'h0, bus.o_Error}, 32'h2);
        bus.i_ErrClr = 1'b1;
        tick();
        bus.i_ErrClr = 1'b0;
        chk("to_err_clear", {30'h0, bus.o_Error}, 32'h0);

        // Accept on the expiry edge wins; then a timeout racing a clear keeps the set
        send(mk(16'h1140, 4'b0001, 2'b00, 1'b0, 32'h0));
        repeat (7) tick();
        send(mk(16'h2220, 4'b0011, 2'b00, 1'b0, 32'h0));
        repeat (7) tick();
        bus.i_ErrClr = 1'b1;
        tick();
        bus.i_ErrClr = 1'b0;
        chk("race_mask", {28'h0, bus.o_DigitMask}, 32'h0);
        chk("race_err_set_wins", {30'h0, bus.o_Error}, 32'h2);

        // Back-pressure while the frame is unacked
        send(mk(16'h1140, 4'b0001, 2'b10, 1'b0, 32'h0));
        send(mk(16'h2220, 4'b0011, 2'b10, 1'b0, 32'h0));
        send(mk(16'h3308, 4'b0111, 2'b10, 1'b0, 32'h0));
        send(mk(16'h4404, 4'b0000, 2'b10, 1'b1, 32'h44332211));
        bus.i_Valid          = 1'b1;
        bus.i_7SegControlled = 16'hEE40;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("stall_ready", {31'h0, bus.o_Ready}, 32'h0);
            chk("stall_valid", {31'h0, bus.o_FrameValid}, 32'h1);
            chk("stall_frame", bus.o_Frame, 32'h44332211);
            chk("stall_mask", {28'h0, bus.o_DigitMask}, 32'h0);
        end
        consume();

        // Asynchronous reset mid-frame
        send(mk(16'h0140, 4'b0001, 2'b10, 1'b0, 32'h0));
        send(mk(16'h0220, 4'b0011, 2'b10, 1'b0, 32'h0));
        send(mk(16'h0308, 4'b0111, 2'b10, 1'b0, 32'h0));
        rst_n = 1'b0;
        #1;
        chk("arst_ready", {31'h0, bus.o_Ready}, 32'h1);
        chk("arst_frame_valid", {31'h0, bus.o_FrameValid}, 32'h0);
        chk("arst_frame", bus.o_Frame, 32'h0);
        chk("arst_mask", {28'h0, bus.o_DigitMask}, 32'h0);
        chk("arst_error", {30'h0, bus.o_Error}, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        send(mk(16'h0540, 4'b0001, 2'b00, 1'b0, 32'h0));
        send(mk(16'h0620, 4'b0011, 2'b00, 1'b0, 32'h0));
        send(mk(16'h0708, 4'b0111, 2'b00, 1'b0, 32'h0));
        send(mk(16'h0804, 4'b0000, 2'b00, 1'b1, 32'h08070605));
        consume();

        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_leftover actual=%0d required=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
